// File: rtl/microseq_unit.sv
// microseq_unit -- microprogram sequencer for the control unit.
//
// Holds the micro-PC (upc) that addresses a combinational microcode memory.
// Each cycle the memory's condition/BT/jump_addr fields for the current upc,
// plus the datapath zero flag z, select the next micro-address.
// Execution starts at address 0 on a start strobe and stops on a taken
// branch to itself (self-loop halt).
//
// Optional build macro: MICROSEQ_STACK_EN adds a STACK_DEPTH-entry return
// stack (call on taken branch with BT=1, return on taken branch to RET_ADDR).
//
// Ports:
//   clk        in  rising-edge clock
//   rst        in  asynchronous active-high reset
//   start      in  one-cycle strobe, (re)starts execution at address 0
//   stall      in  freezes all sequencer state
//   z          in  datapath zero flag
//   condition  in  [1:0] 00 never, 01 always, 10 if z, 11 if !z
//   BT         in  branch type, 1 = call when taken (stack build only)
//   jump_addr  in  [ADDR_W-1:0] branch target
//   upc        out [ADDR_W-1:0] registered micro-PC
//   running    out high in RUN
//   done       out high in HALT
//   err        out sticky stack overflow/underflow, 0 without the stack
module microseq_unit #(
  parameter int unsigned          ADDR_W      = 16,
  parameter int unsigned          STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    RET_ADDR    = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              z,
  input  logic [1:0]        condition,
  input  logic              BT,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] upc,
  output logic              running,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] upc_nxt;
  logic [ADDR_W-1:0] upc_inc;
  logic              err_nxt;
  logic              taken;

  assign upc_inc = upc + 1'b1;

  always_comb begin
    taken = 1'b0;
    unique case (condition)
      2'b00: taken = 1'b0;
      2'b01: taken = 1'b1;
      2'b10: taken = z;
      2'b11: taken = ~z;
    endcase
  end

`ifdef MICROSEQ_STACK_EN
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp, sp_nxt;
  logic              push_en;
  logic              stack_full, stack_empty;
  logic [IDX_W-1:0]  top_idx;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = IDX_W'(sp - 1'b1);
`endif

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    err_nxt   = err;
`ifdef MICROSEQ_STACK_EN
    sp_nxt    = sp;
    push_en   = 1'b0;
`endif
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = RUN;
          upc_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (!taken) begin
          upc_nxt = upc_inc;
`ifdef MICROSEQ_STACK_EN
        end else if (jump_addr == RET_ADDR) begin
          // Returns bypass the self-loop halt check; an empty pop falls through.
          if (stack_empty) begin
            err_nxt = 1'b1;
            upc_nxt = upc_inc;
          end else begin
            sp_nxt  = sp - 1'b1;
            upc_nxt = stack[top_idx];
          end
`endif
        end else begin
`ifdef MICROSEQ_STACK_EN
          if (BT) begin
            // Overflowing call still jumps; only the return address is lost.
            if (stack_full) begin
              err_nxt = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_nxt  = sp + 1'b1;
            end
          end
`endif
          upc_nxt = jump_addr;
          if (jump_addr == upc) state_nxt = HALT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      upc   <= '0;
      err   <= 1'b0;
    end else if (!stall) begin
      state <= state_nxt;
      upc   <= upc_nxt;
      err   <= err_nxt;
    end
  end

`ifdef MICROSEQ_STACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp <= '0;
    else if (!stall) sp <= sp_nxt;
  end

  // Storage needs no reset: entries are only read below sp.
  always_ff @(posedge clk) begin
    if (!stall && push_en) stack[sp[IDX_W-1:0]] <= upc_inc;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{BT, RET_ADDR, ADDR_W'(STACK_DEPTH)};
`endif

  assign running = (state == RUN);
  assign done    = (state == HALT);

endmodule

// File: tb/tb_microseq_unit.sv
module tb_microseq_unit;

  logic        clk = 1'b0;
  logic        rst, start, stall, z, BT;
  logic [1:0]  condition;
  logic [15:0] jump_addr;
  logic [15:0] upc;
  logic        running, done, err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  microseq_unit #(.ADDR_W(16), .STACK_DEPTH(4), .RET_ADDR(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .z(z),
    .condition(condition), .BT(BT), .jump_addr(jump_addr),
    .upc(upc), .running(running), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic uop(input logic [1:0] c, input logic zz, input logic bt, input logic [15:0] ja);
    condition = c;
    z         = zz;
    BT        = bt;
    jump_addr = ja;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; z = 1'b0; BT = 1'b0;
    condition = 2'b00; jump_addr = '0;
    #3 rst = 1'b0;
    repeat (5) tick();
    check("rst_upc", upc, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    start = 1'b1; tick(); start = 1'b0;
    check("start_running", running, 1);
    check("start_upc", upc, 0);
    uop(2'b00, 0, 0, 16'h0040); check("seq1", upc, 1);
    uop(2'b00, 0, 0, 16'h0040); check("seq2", upc, 2);
    // start while running is ignored
    start = 1'b1;
    uop(2'b00, 0, 0, 16'h0040); check("seq3_start_ign", upc, 3);
    start = 1'b0;

    uop(2'b10, 1, 0, 16'h0040); check("cz_taken", upc, 16'h0040);
    uop(2'b01, 0, 0, 16'h0003); check("back3a", upc, 3);
    uop(2'b10, 0, 0, 16'h0040); check("cz_not_taken", upc, 4);
    uop(2'b01, 0, 0, 16'h0003); check("back3b", upc, 3);
    uop(2'b11, 0, 0, 16'h0040); check("cnz_taken", upc, 16'h0040);
    uop(2'b01, 0, 0, 16'h0003); check("back3c", upc, 3);
    uop(2'b11, 1, 0, 16'h0040); check("cnz_not_taken", upc, 4);

    uop(2'b01, 0, 0, 16'h0007); check("to7", upc, 7);
    condition = 2'b01; jump_addr = 16'h0100; stall = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_upc", upc, 7);
      check("stall_running", running, 1);
    end
    stall = 1'b0; start = 1'b0;
    uop(2'b01, 0, 0, 16'h0100); check("stall_release", upc, 16'h0100);

    uop(2'b01, 0, 0, 16'h0009); check("to9", upc, 9);
    check("pre_halt_done", done, 0);
    uop(2'b01, 0, 0, 16'h0009);
    check("halt_done", done, 1);
    check("halt_running", running, 0);
    check("halt_upc", upc, 9);
    uop(2'b00, 0, 0, 16'h0000);
    check("halt_hold", upc, 9);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_upc", upc, 0);
    check("restart_running", running, 1);
    check("restart_done", done, 0);

`ifndef MICROSEQ_STACK_EN
    uop(2'b01, 0, 1, 16'hFFFF); check("to_ffff", upc, 16'hFFFF);
    check("ffff_running", running, 1);
    uop(2'b00, 0, 0, 16'h1234); check("wrap", upc, 0);
    check("wrap_err", err, 0);
`endif

    uop(2'b01, 0, 0, 16'h0005); check("to5", upc, 5);
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_upc", upc, 0);
    check("async_rst_running", running, 0);
    check("async_rst_done", done, 0);
    #1 rst = 1'b0; stall = 1'b0;
    tick();
    check("post_rst_idle", running, 0);

`ifdef MICROSEQ_STACK_EN
    start = 1'b1; tick(); start = 1'b0;
    uop(2'b00, 0, 0, 16'h0000);
    uop(2'b00, 0, 0, 16'h0000); check("stk_at2", upc, 2);
    uop(2'b01, 0, 1, 16'h0020); check("call", upc, 16'h0020);
    uop(2'b01, 0, 0, 16'hFFFF); check("ret", upc, 3);
    check("ret_err", err, 0);
    for (int i = 0; i < 5; i++) begin
      uop(2'b01, 0, 1, 16'h0010 + 16'(i));
      check("nest_upc", upc, 16'h0010 + i);
      check("nest_err", err, (i == 4) ? 1 : 0);
    end
    uop(2'b01, 0, 0, 16'hFFFF); check("pop1", upc, 16'h0013);
    uop(2'b01, 0, 0, 16'hFFFF); check("pop2", upc, 16'h0012);
    uop(2'b01, 0, 0, 16'hFFFF); check("pop3", upc, 16'h0011);
    uop(2'b01, 0, 0, 16'hFFFF); check("pop4", upc, 4);
    rst = 1'b1; #1 rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    uop(2'b01, 0, 0, 16'h0006); check("to6", upc, 6);
    check("to6_err", err, 0);
    uop(2'b01, 0, 0, 16'hFFFF);
    check("underflow_upc", upc, 7);
    check("underflow_err", err, 1);
    check("underflow_running", running, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
